// File: rtl/pipe_common_pkg.sv
// Shared pipeline definitions: register count, stage indices and the
// machine word type used for PCs.
// No ports.
package pipe_common_pkg;

   localparam int NSTAGE = 6;

   // Index of each pipeline register in the stall/flush vectors.
   typedef enum logic [2:0] {
      ST_F = 3'd0,
      ST_D = 3'd1,
      ST_R = 3'd2,
      ST_I = 3'd3,
      ST_E = 3'd4,
      ST_C = 3'd5
   } stage_e;

   typedef logic [31:0] word_t;

endpackage

// File: rtl/pipe_ctrl_pkg.sv
// Types private to the pipeline stall/flush sequencer: FSM states, the
// kind of redirect held pending, and the performance counter bundle.
// No ports.
package pipe_ctrl_pkg;
   import pipe_common_pkg::*;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      WAIT_MEM   = 2'd1,
      WAIT_FETCH = 2'd2
   } ctrl_state_e;

   typedef enum logic {
      RK_BR  = 1'b0,
      RK_EXC = 1'b1
   } redir_kind_e;

   typedef struct packed {
      logic [NSTAGE-1:0][CNT_W-1:0] stall_cyc;
      logic [CNT_W-1:0]             br_flush;
      logic [CNT_W-1:0]             exc_flush;
      logic [CNT_W-1:0]             wait_cyc;
   } perf_cnt_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating performance counters for the pipeline sequencer.
// Only instantiated when PIPE_CTRL_PERF_EN is defined.
// Ports:
//   clk, resetn   clock, synchronous active-low reset (clears all counters)
//   stall         per-register stall, one count per stalled cycle
//   br_flush      a branch redirect was issued this cycle
//   exc_flush     an exception redirect was issued this cycle
//   waiting       sequencer is in a WAIT_* state
//   perf          counter bundle
module pipe_ctrl_perf
   import pipe_common_pkg::*;
   import pipe_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic [NSTAGE-1:0] stall,
   input  logic              br_flush,
   input  logic              exc_flush,
   input  logic              waiting,
   output perf_cnt_t         perf
);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         perf <= '0;
      end else begin
         for (int k = 0; k < NSTAGE; k++) begin
            if (stall[k]) perf.stall_cyc[k] <= sat_inc(perf.stall_cyc[k]);
         end
         if (br_flush)  perf.br_flush  <= sat_inc(perf.br_flush);
         if (exc_flush) perf.exc_flush <= sat_inc(perf.exc_flush);
         if (waiting)   perf.wait_cyc  <= sat_inc(perf.wait_cyc);
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the six pipeline registers F D R I E C.
// Merges per-stage stall requests with branch redirects (from E) and
// exception redirects (from C), drives per-register stall/flush and the
// fetch-PC override, and parks a redirect while the I-side or D-side is busy.
// Optional feature macro: PIPE_CTRL_PERF_EN adds the perf_o counter port.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   stall_req          stage k cannot advance its output this cycle
//   fetch_busy         I-side request outstanding, PC must not change
//   mem_busy           D-side access in flight, exception must wait
//   br_redirect/br_pc  mispredict pulse from E and its target
//   exc_redirect/exc_pc exception/eret pulse from C and its target
//   stall, flush       per-register controls (flush[0] always 0)
//   redirect_valid/pc  one-cycle PC override into freg
//   ctrl_idle          sequencer in RUN
//   perf_o             counters (PIPE_CTRL_PERF_EN only)
//
// state      | meaning
// -----------+---------------------------------------------------------
// RUN        | normal flow, redirects issued immediately when possible
// WAIT_MEM   | exception parked until the D-side drains; whole pipe held
// WAIT_FETCH | redirect parked until the I-side is free; F held, D..E
//            | (and C for exceptions) flushed every cycle
module pipe_ctrl
   import pipe_common_pkg::*;
   import pipe_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic [NSTAGE-1:0] stall_req,
   input  logic              fetch_busy,
   input  logic              mem_busy,
   input  logic              br_redirect,
   input  word_t             br_pc,
   input  logic              exc_redirect,
   input  word_t             exc_pc,
   output logic [NSTAGE-1:0] stall,
   output logic [NSTAGE-1:0] flush,
   output logic              redirect_valid,
   output word_t             redirect_pc,
   output logic              ctrl_idle
`ifdef PIPE_CTRL_PERF_EN
   ,
   output perf_cnt_t         perf_o
`endif
);

   ctrl_state_e state, state_nxt;
   word_t       pend_pc, pend_pc_nxt;
   redir_kind_e pend_kind, pend_kind_nxt;

   // A fresh exception arriving while parked replaces the pending target.
   word_t       tgt_pc;
   logic        tgt_exc;

   logic [NSTAGE-1:0] hold;
   logic [NSTAGE-1:0] ctrl_flush;
   logic [NSTAGE-1:0] req_eff;
   logic [NSTAGE-1:0] stall_raw;
   logic [NSTAGE-1:0] flush_all;
   logic              rv_int;
   word_t             rpc_int;

   assign tgt_pc  = exc_redirect ? exc_pc : pend_pc;
   assign tgt_exc = exc_redirect | (pend_kind == RK_EXC);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= RUN;
         pend_pc   <= '0;
         pend_kind <= RK_BR;
      end else begin
         state     <= state_nxt;
         pend_pc   <= pend_pc_nxt;
         pend_kind <= pend_kind_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pend_pc_nxt   = pend_pc;
      pend_kind_nxt = pend_kind;
      case (state)
         RUN: begin
            if (exc_redirect) begin
               if (mem_busy || fetch_busy) begin
                  pend_pc_nxt   = exc_pc;
                  pend_kind_nxt = RK_EXC;
                  state_nxt     = mem_busy ? WAIT_MEM : WAIT_FETCH;
               end
            end else if (br_redirect && fetch_busy) begin
               pend_pc_nxt   = br_pc;
               pend_kind_nxt = RK_BR;
               state_nxt     = WAIT_FETCH;
            end
         end
         WAIT_MEM: begin
            if (exc_redirect) begin
               pend_pc_nxt   = exc_pc;
               pend_kind_nxt = RK_EXC;
            end
            if (!mem_busy) state_nxt = fetch_busy ? WAIT_FETCH : RUN;
         end
         WAIT_FETCH: begin
            if (exc_redirect) begin
               pend_pc_nxt   = exc_pc;
               pend_kind_nxt = RK_EXC;
            end
            // A new exception behind a busy D-side must wait for it first.
            if (exc_redirect && mem_busy) state_nxt = WAIT_MEM;
            else if (!fetch_busy)         state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      hold       = '0;
      ctrl_flush = '0;
      rv_int     = 1'b0;
      rpc_int    = pend_pc;
      case (state)
         RUN: begin
            if (exc_redirect) begin
               if (!mem_busy && !fetch_busy) begin
                  ctrl_flush[ST_C:ST_D] = '1;
                  rv_int                = 1'b1;
                  rpc_int               = exc_pc;
               end
            end else if (br_redirect) begin
               ctrl_flush[ST_E:ST_D] = '1;
               if (!fetch_busy) begin
                  rv_int  = 1'b1;
                  rpc_int = br_pc;
               end
            end
         end
         WAIT_MEM: begin
            if (mem_busy || fetch_busy) begin
               hold = '1;
            end else begin
               ctrl_flush[ST_C:ST_D] = '1;
               rv_int                = 1'b1;
               rpc_int               = tgt_pc;
            end
         end
         WAIT_FETCH: begin
            ctrl_flush[ST_E:ST_D] = '1;
            ctrl_flush[ST_C]      = tgt_exc;
            if (fetch_busy || (exc_redirect && mem_busy)) begin
               hold[ST_F] = 1'b1;
            end else begin
               rv_int  = 1'b1;
               rpc_int = tgt_pc;
            end
         end
         default: ;
      endcase

      // Requests from squashed stages must not stall or bubble anything.
      req_eff = stall_req & ~ctrl_flush;
      for (int k = 0; k < NSTAGE; k++) begin
         stall_raw[k] = (|(req_eff >> k)) | hold[k];
      end

      flush_all = ctrl_flush;
      for (int k = 0; k < NSTAGE - 1; k++) begin
         flush_all[k+1] = flush_all[k+1] | (stall_raw[k] & ~stall_raw[k+1]);
      end
      flush_all[ST_F] = 1'b0;

      if (!resetn) begin
         stall          = '0;
         flush          = {{(NSTAGE-1){1'b1}}, 1'b0};
         redirect_valid = 1'b0;
      end else begin
         stall          = stall_raw & ~flush_all;
         flush          = flush_all;
         redirect_valid = rv_int;
      end
      redirect_pc = rpc_int;
   end

   assign ctrl_idle = (state == RUN);

`ifdef PIPE_CTRL_PERF_EN
   logic perf_br, perf_exc;

   // In RUN an issued redirect is an exception only if exc_redirect is up;
   // parked redirects carry their kind in tgt_exc.
   assign perf_exc = redirect_valid & ((state == RUN) ? exc_redirect : tgt_exc);
   assign perf_br  = redirect_valid & ~perf_exc;

   pipe_ctrl_perf u_perf (
      .clk       (clk),
      .resetn    (resetn),
      .stall     (stall),
      .br_flush  (perf_br),
      .exc_flush (perf_exc),
      .waiting   (state != RUN),
      .perf      (perf_o)
   );
`endif

endmodule
